// File: rtl/lc3_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_regfile_pkg
// Purpose  : Shared types and constants for the LC-3 register-file write side.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_regfile_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  // JSR/TRAP linkage always targets R7
  localparam reg_idx_t   R7_IDX   = 3'd7;
  // NZP after reset: Z set
  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } wr_state_t;

  // One buffered write captured while WR_HOLD blocks commits
  typedef struct packed {
    reg_idx_t dr;
    word_t    data;
    logic     ld_cc;
  } held_wr_t;

endpackage
`default_nettype wire

// File: rtl/dr_write_regfile_cc_gen.sv
`default_nettype none
// ============================================================================
// Module   : cc_gen
// Purpose  : Combinational NZP generation from a data word. Exactly one of
//            the three flags is high for any input.
// Revision : 1.0 - initial release
// ============================================================================
module cc_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] word,
  output logic [2:0]       nzp
);

  // Sign bit wins, then zero test, otherwise positive
  always_comb begin
    nzp = 3'b001;
    if (word[WIDTH-1]) begin
      nzp = 3'b100;
    end else if (word == '0) begin
      nzp = 3'b010;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dr_write_regfile.sv
`default_nettype none
// ============================================================================
// Module   : dr_write_regfile
// Purpose  : LC-3 register-file write side: DRMUX, write strobe, NZP update
//            and a one-entry buffer that holds a write while WR_HOLD is high.
// Config   : DR_WRITE_BYPASS_EN - when defined, R[buffered dr] and NZP show
//            the pending buffered write while in HELD.
// Revision : 1.0 - initial release
// ============================================================================
module dr_write_regfile #(
  parameter int         WIDTH    = 16,
  parameter int         NREG     = 8,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [2:0]       IR_DR,
  input  logic             DR_MUX,
  input  logic [WIDTH-1:0] BUS,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             WR_HOLD,
  output logic             WR_READY,
  output logic             WR_PENDING,
  output logic             OVERRUN,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic             N,
  output logic             Z,
  output logic             P
);
  import lc3_regfile_pkg::*;

  wr_state_t        state;
  wr_state_t        state_nxt;
  held_wr_t         hbuf;
  logic [WIDTH-1:0] regs [NREG];
  logic [2:0]       nzp;
  logic             overrun;

  reg_idx_t         dr;
  logic             capture;
  logic             wr_en;
  reg_idx_t         wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             cc_en;
  logic             cc_sel_buf;
  logic             ovr_set;
  logic [WIDTH-1:0] cc_word;
  logic [2:0]       cc_commit;

  logic [WIDTH-1:0] rd [NREG];
  logic [2:0]       nzp_out;

  assign dr = DR_MUX ? R7_IDX : IR_DR;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state plus write/CC/overrun strobes decoded from state and inputs
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = dr;
    wr_data    = BUS;
    cc_en      = 1'b0;
    cc_sel_buf = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      EMPTY: begin
        if (LD_REG) begin
          if (WR_HOLD) begin
            capture   = 1'b1;
            state_nxt = HELD;
          end else begin
            wr_en = 1'b1;
            cc_en = LD_CC;
          end
        end else begin
          cc_en = LD_CC;
        end
      end
      HELD: begin
        // A write request here is dropped; its paired LD_CC goes with it
        ovr_set = LD_REG;
        cc_en   = LD_CC && !LD_REG;
        if (!WR_HOLD) begin
          state_nxt = EMPTY;
          wr_en     = 1'b1;
          wr_idx    = hbuf.dr;
          wr_data   = hbuf.data;
          // Buffered CC update outranks a same-edge CC-only strobe
          if (hbuf.ld_cc) begin
            cc_en      = 1'b1;
            cc_sel_buf = 1'b1;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign cc_word = cc_sel_buf ? hbuf.data : BUS;

  cc_gen #(.WIDTH(WIDTH)) u_cc_commit (
    .word (cc_word),
    .nzp  (cc_commit)
  );

  // Held-write buffer; cleared on reset so a held write never survives it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       hbuf <= '0;
    else if (capture) hbuf <= '{dr: dr, data: BUS, ld_cc: LD_CC};
  end

  // Register array
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Condition codes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)     nzp <= CC_RESET;
    else if (cc_en) nzp <= cc_commit;
  end

  // Sticky overrun flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)        overrun <= 1'b0;
    else if (ovr_set)  overrun <= 1'b1;
  end

`ifdef DR_WRITE_BYPASS_EN
  logic [2:0] cc_bypass;

  cc_gen #(.WIDTH(WIDTH)) u_cc_bypass (
    .word (hbuf.data),
    .nzp  (cc_bypass)
  );

  // Readers see the pending buffered value while the hold is active
  always_comb begin
    for (int i = 0; i < NREG; i++) rd[i] = regs[i];
    nzp_out = nzp;
    if (state == HELD) begin
      rd[hbuf.dr] = hbuf.data;
      if (hbuf.ld_cc) nzp_out = cc_bypass;
    end
  end
`else
  // Outputs reflect only the committed array and NZP
  always_comb begin
    for (int i = 0; i < NREG; i++) rd[i] = regs[i];
    nzp_out = nzp;
  end
`endif

  assign WR_READY   = (state == EMPTY);
  assign WR_PENDING = (state == HELD);
  assign OVERRUN    = overrun;
  assign R0 = rd[0];
  assign R1 = rd[1];
  assign R2 = rd[2];
  assign R3 = rd[3];
  assign R4 = rd[4];
  assign R5 = rd[5];
  assign R6 = rd[6];
  assign R7 = rd[7];
  assign {N, Z, P} = nzp_out;

endmodule
`default_nettype wire

// File: tb/tb_dr_write_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_dr_write_regfile
// Purpose  : Directed self-checking bench for dr_write_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dr_write_regfile;

  logic        Clk;
  logic        Reset;
  logic [2:0]  IR_DR;
  logic        DR_MUX;
  logic [15:0] BUS;
  logic        LD_REG;
  logic        LD_CC;
  logic        WR_HOLD;
  logic        WR_READY;
  logic        WR_PENDING;
  logic        OVERRUN;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic        N, Z, P;
  logic [15:0] rv [8];
  logic [2:0]  nzp;

  int total = 0;
  int bad   = 0;

  dr_write_regfile dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IR_DR      (IR_DR),
    .DR_MUX     (DR_MUX),
    .BUS        (BUS),
    .LD_REG     (LD_REG),
    .LD_CC      (LD_CC),
    .WR_HOLD    (WR_HOLD),
    .WR_READY   (WR_READY),
    .WR_PENDING (WR_PENDING),
    .OVERRUN    (OVERRUN),
    .R0         (r0),
    .R1         (r1),
    .R2         (r2),
    .R3         (r3),
    .R4         (r4),
    .R5         (r5),
    .R6         (r6),
    .R7         (r7),
    .N          (N),
    .Z          (Z),
    .P          (P)
  );

  assign rv[0] = r0;
  assign rv[1] = r1;
  assign rv[2] = r2;
  assign rv[3] = r3;
  assign rv[4] = r4;
  assign rv[5] = r5;
  assign rv[6] = r6;
  assign rv[7] = r7;
  assign nzp   = {N, Z, P};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drop all strobes
  task automatic idle();
    LD_REG  = 1'b0;
    LD_CC   = 1'b0;
    WR_HOLD = 1'b0;
    DR_MUX  = 1'b0;
    IR_DR   = 3'd0;
    BUS     = 16'h0000;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b0;
    #12;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rv[i] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_r%0d: got %h expected 0000", i, rv[i]);
      end
    end
    total++;
    if ({nzp, WR_READY, WR_PENDING, OVERRUN} !== 6'b010_1_0_0) begin
      bad++;
      $display("FAIL reset_flags: got nzp=%b rdy=%b pend=%b ovr=%b expected 010 1 0 0",
               nzp, WR_READY, WR_PENDING, OVERRUN);
    end
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    tick();
    total++;
    if ({nzp, WR_READY, r0, r7} !== {3'b010, 1'b1, 16'h0, 16'h0}) begin
      bad++;
      $display("FAIL reset_release: got nzp=%b rdy=%b r0=%h r7=%h expected 010 1 0000 0000",
               nzp, WR_READY, r0, r7);
    end
  endtask

  task automatic test_direct_write();
    IR_DR = 3'd3; DR_MUX = 1'b0; BUS = 16'h8001; LD_REG = 1'b1; LD_CC = 1'b1;
    tick();
    idle();
    total++;
    if (rv[3] !== 16'h8001 || nzp !== 3'b100) begin
      bad++;
      $display("FAIL direct_r3: got r3=%h nzp=%b expected 8001 100", rv[3], nzp);
    end
    IR_DR = 3'd3; DR_MUX = 1'b1; BUS = 16'h3000; LD_REG = 1'b1;
    tick();
    idle();
    total++;
    if (rv[7] !== 16'h3000 || rv[3] !== 16'h8001 || nzp !== 3'b100) begin
      bad++;
      $display("FAIL drmux_r7: got r7=%h r3=%h nzp=%b expected 3000 8001 100",
               rv[7], rv[3], nzp);
    end
  endtask

  task automatic test_cc_only();
    WR_HOLD = 1'b1; LD_CC = 1'b1; BUS = 16'h0005;
    tick();
    idle();
    total++;
    if (nzp !== 3'b001 || WR_READY !== 1'b1 || WR_PENDING !== 1'b0) begin
      bad++;
      $display("FAIL cc_only: got nzp=%b rdy=%b pend=%b expected 001 1 0",
               nzp, WR_READY, WR_PENDING);
    end
  endtask

  task automatic test_hold();
    WR_HOLD = 1'b1; LD_REG = 1'b1; IR_DR = 3'd5; BUS = 16'h0000; LD_CC = 1'b1;
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (WR_PENDING !== 1'b1 || WR_READY !== 1'b0 || rv[5] !== 16'h0000
`ifndef DR_WRITE_BYPASS_EN
          || nzp !== 3'b001
`endif
         ) begin
        bad++;
        $display("FAIL hold_cycle%0d: got pend=%b rdy=%b r5=%h nzp=%b expected 1 0 0000 001",
                 c, WR_PENDING, WR_READY, rv[5], nzp);
      end
      tick();
    end
    WR_HOLD = 1'b0;
    tick();
    total++;
    if (rv[5] !== 16'h0000 || nzp !== 3'b010 || WR_READY !== 1'b1 || WR_PENDING !== 1'b0) begin
      bad++;
      $display("FAIL hold_commit: got r5=%h nzp=%b rdy=%b pend=%b expected 0000 010 1 0",
               rv[5], nzp, WR_READY, WR_PENDING);
    end
  endtask

  task automatic test_overrun();
    WR_HOLD = 1'b1; LD_REG = 1'b1; IR_DR = 3'd4; BUS = 16'h7777; LD_CC = 1'b0;
    tick();
    total++;
    if (OVERRUN !== 1'b0 || WR_PENDING !== 1'b1) begin
      bad++;
      $display("FAIL ovr_capture: got ovr=%b pend=%b expected 0 1", OVERRUN, WR_PENDING);
    end
    LD_REG = 1'b1; IR_DR = 3'd2; BUS = 16'h1234;
    tick();
    total++;
    if (OVERRUN !== 1'b1 || WR_PENDING !== 1'b1 || rv[2] !== 16'h0000) begin
      bad++;
      $display("FAIL ovr_set: got ovr=%b pend=%b r2=%h expected 1 1 0000",
               OVERRUN, WR_PENDING, rv[2]);
    end
    LD_REG = 1'b0; LD_CC = 1'b1; BUS = 16'hFFFF;
    tick();
    total++;
    if (nzp !== 3'b100) begin
      bad++;
      $display("FAIL held_cc_only: got nzp=%b expected 100", nzp);
    end
    LD_CC = 1'b0; WR_HOLD = 1'b0; LD_REG = 1'b1; IR_DR = 3'd2; BUS = 16'h1234;
    tick();
    idle();
    total++;
    if (rv[4] !== 16'h7777 || rv[2] !== 16'h0000 || nzp !== 3'b100
        || OVERRUN !== 1'b1 || WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL ovr_commit: got r4=%h r2=%h nzp=%b ovr=%b rdy=%b expected 7777 0000 100 1 1",
               rv[4], rv[2], nzp, OVERRUN, WR_READY);
    end
    tick();
    total++;
    if (OVERRUN !== 1'b1 || rv[2] !== 16'h0000) begin
      bad++;
      $display("FAIL ovr_sticky: got ovr=%b r2=%h expected 1 0000", OVERRUN, rv[2]);
    end
  endtask

  task automatic test_cc_priority();
    WR_HOLD = 1'b1; LD_REG = 1'b1; IR_DR = 3'd6; BUS = 16'h0001; LD_CC = 1'b1;
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0;
    tick();
    WR_HOLD = 1'b0; LD_CC = 1'b1; BUS = 16'h8000;
    tick();
    idle();
    total++;
    if (rv[6] !== 16'h0001 || nzp !== 3'b001) begin
      bad++;
      $display("FAIL cc_priority: got r6=%h nzp=%b expected 0001 001", rv[6], nzp);
    end
  endtask

  task automatic test_back_to_back();
    LD_REG = 1'b1; IR_DR = 3'd0; BUS = 16'h1111;
    tick();
    total++;
    if (rv[0] !== 16'h1111) begin
      bad++;
      $display("FAIL b2b_first: got r0=%h expected 1111", rv[0]);
    end
    BUS = 16'h2222;
    tick();
    idle();
    total++;
    if (rv[0] !== 16'h2222) begin
      bad++;
      $display("FAIL b2b_last: got r0=%h expected 2222", rv[0]);
    end
  endtask

  task automatic test_bypass();
    LD_CC = 1'b1; BUS = 16'h8000;
    tick();
    idle();
    WR_HOLD = 1'b1; LD_REG = 1'b1; IR_DR = 3'd1; BUS = 16'h0042; LD_CC = 1'b1;
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0; BUS = 16'h0000;
    for (int c = 0; c < 2; c++) begin
`ifdef DR_WRITE_BYPASS_EN
      total++;
      if (rv[1] !== 16'h0042 || nzp !== 3'b001) begin
        bad++;
        $display("FAIL bypass_view%0d: got r1=%h nzp=%b expected 0042 001", c, rv[1], nzp);
      end
`else
      total++;
      if (rv[1] !== 16'h0000 || nzp !== 3'b100) begin
        bad++;
        $display("FAIL nobypass_view%0d: got r1=%h nzp=%b expected 0000 100", c, rv[1], nzp);
      end
`endif
      tick();
    end
    WR_HOLD = 1'b0;
    tick();
    total++;
    if (rv[1] !== 16'h0042 || nzp !== 3'b001) begin
      bad++;
      $display("FAIL bypass_commit: got r1=%h nzp=%b expected 0042 001", rv[1], nzp);
    end
  endtask

  task automatic test_reset_held();
    WR_HOLD = 1'b1; LD_REG = 1'b1; IR_DR = 3'd3; BUS = 16'hBEEF; LD_CC = 1'b1;
    tick();
    LD_REG = 1'b0; LD_CC = 1'b0;
    total++;
    if (WR_PENDING !== 1'b1) begin
      bad++;
      $display("FAIL rh_pending: got pend=%b expected 1", WR_PENDING);
    end
    #2;
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rv[i] !== 16'h0000) begin
        bad++;
        $display("FAIL rh_async_r%0d: got %h expected 0000", i, rv[i]);
      end
    end
    total++;
    if ({nzp, WR_READY, WR_PENDING, OVERRUN} !== 6'b010_1_0_0) begin
      bad++;
      $display("FAIL rh_flags: got nzp=%b rdy=%b pend=%b ovr=%b expected 010 1 0 0",
               nzp, WR_READY, WR_PENDING, OVERRUN);
    end
    @(negedge Clk);
    Reset   = 1'b1;
    WR_HOLD = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rv[i] !== 16'h0000) begin
        bad++;
        $display("FAIL rh_lost_r%0d: got %h expected 0000", i, rv[i]);
      end
    end
    total++;
    if (nzp !== 3'b010 || WR_READY !== 1'b1) begin
      bad++;
      $display("FAIL rh_after: got nzp=%b rdy=%b expected 010 1", nzp, WR_READY);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_cc_only();
    test_hold();
    test_overrun();
    test_cc_priority();
    test_back_to_back();
    test_bypass();
    test_reset_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dr_write_regfile.md
Name: dr_write_regfile

Overview:
- Write side of the LC-3 general-purpose register file: destination-register select (DRMUX), write strobe, condition-code (NZP) generation, and a one-entry held-write buffer.
- Stores R0..R7 and drives them out in parallel to the source-register read muxes.
- Takes writeback data from the datapath BUS under control-FSM strobes.
- When WR_HOLD is asserted (e.g. register snapshot or debug read), writes are buffered and committed once the hold releases.

Parameters:
- WIDTH, 16, data word width.
- NREG, 8, number of registers; fixed at 8, so the index width is 3.
- CC_RESET, 3'b010, NZP value loaded at reset (Z set).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IR_DR  input  3  IR[11:9] destination field.
- DR_MUX  input  1  0: dest = IR_DR; 1: dest = 3'd7 (JSR/TRAP linkage).
- BUS  input  WIDTH  writeback data.
- LD_REG  input  1  write request (valid); sampled only when WR_READY=1.
- LD_CC  input  1  update NZP from BUS; qualified like LD_REG when paired with it.
- WR_HOLD  input  1  block commits to the register array.
- WR_READY  output  1  buffer empty; a write request will be accepted.
- WR_PENDING  output  1  a held write is buffered.
- OVERRUN  output  1  sticky; LD_REG arrived while WR_READY=0.
- R0..R7  output  WIDTH each  register contents.
- N, Z, P  output  1 each  condition codes.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - R0..R7 = 0; {N,Z,P} = CC_RESET.
  - State EMPTY; WR_READY = 1; WR_PENDING = 0; OVERRUN = 0.
  - Buffer contents discarded, including reset asserted during HELD.
- Destination index: dr = DR_MUX ? 3'd7 : IR_DR. Evaluated in the cycle LD_REG is sampled and captured with the data.
- CC rule, computed on the committed word:
  - word[15] = 1 -> N=1, Z=0, P=0.
  - word = 0 -> Z=1, N=0, P=0.
  - Otherwise P=1, N=0, Z=0.
  - Exactly one of N, Z, P is high at all times.
- State EMPTY (WR_READY=1, WR_PENDING=0):
  - LD_REG=1 and WR_HOLD=0: at the edge, R[dr] <= BUS; if LD_CC, NZP <= cc(BUS). Stay EMPTY. Latency 1 cycle; the new value is visible on R[dr] the next cycle.
  - LD_REG=1 and WR_HOLD=1: capture {dr, BUS, LD_CC} into the buffer; go to HELD. Register array and NZP are unchanged.
  - LD_CC=1 with LD_REG=0: NZP <= cc(BUS) at the edge, regardless of WR_HOLD (CC-only update).
- State HELD (WR_READY=0, WR_PENDING=1):
  - WR_HOLD=1: remain in HELD; the buffer is stable.
  - WR_HOLD=0 at an edge: commit the buffered write (register plus CC if its flag is set); go to EMPTY. WR_READY returns to 1 in the following cycle.
  - LD_REG=1 in any HELD cycle, including the commit cycle: request dropped, OVERRUN <= 1 (sticky until reset).
  - LD_CC-only in HELD: applied immediately. A buffered CC update committing in the same edge takes priority.
- Repeated writes to the same register in consecutive EMPTY cycles: last write wins; no hazard logic.
- WR_HOLD has no effect in EMPTY unless LD_REG is asserted.
- All outputs are registered except WR_READY and WR_PENDING, which are decoded from state.

Optional Feature:
- Macro: DR_WRITE_BYPASS_EN.
- Defined: while HELD, output R[buffered dr] shows the buffered data, and N/Z/P show cc(buffered data) if the buffered CC flag is set. Readers therefore see the pending value during the hold.
- Undefined: outputs always reflect the committed array and NZP only.

Decomposition:
- Package lc3_regfile_pkg:
  - word_t (logic [15:0]) and reg_idx_t (logic [2:0]).
  - Constant R7_IDX = 3'd7 and constant CC_RESET.
  - wr_state_t enum {EMPTY, HELD}.
  - Struct held_wr_t {reg_idx_t dr; word_t data; logic ld_cc}.
- One sub-module, cc_gen: combinational word -> {N,Z,P}. It is instantiated for the commit path and, when DR_WRITE_BYPASS_EN is defined, for the bypass path.

Test Plan:
1. Reset low mid-run -> all R = 0, NZP = 010, WR_READY = 1, OVERRUN = 0; release -> state unchanged until the first strobe.
2. IR_DR=3, DR_MUX=0, BUS=16'h8001, LD_REG=1, LD_CC=1, WR_HOLD=0 -> next cycle R3 = 8001, N=1; then DR_MUX=1, BUS=16'h3000 -> R7 = 3000 and R3 is unchanged.
3. WR_HOLD=1, LD_REG with IR_DR=5, BUS=0, LD_CC=1 -> WR_PENDING=1, R5 and NZP unchanged for 4 hold cycles; drop WR_HOLD -> R5 = 0, Z=1, WR_READY=1 the next cycle.
4. During HELD, assert LD_REG with BUS=16'h1234 to R2 -> R2 stays 0, OVERRUN=1 and remains 1 after commit.
5. Reset asserted while HELD with buffered data 16'hBEEF -> buffer lost; after release, no register holds BEEF.
6. With DR_WRITE_BYPASS_EN: hold a write of 16'h0042 to R1 -> R1 output reads 0042 and P=1 during HELD; without the macro, R1 reads its old value until commit.
